// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings and lane-placement helpers for the load/store unit.
// Lane geometry is expressed as a bit shift plus a lane-wide mask.
package lsu_mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_t;

  function automatic int size_bytes(input logic [1:0] size);
    int n;
    case (size)
      SZ_BYTE: n = 1;
      SZ_HALF: n = 2;
      default: n = 4;
    endcase
    return n;
  endfunction

  // Big-endian puts byte offset 0 in the most significant lane.
  function automatic logic [4:0] lane_shift(input logic [1:0] off, input logic [1:0] size,
                                            input logic big_endian);
    int s;
    if (big_endian) s = 8 * (4 - size_bytes(size) - int'(off));
    else            s = 8 * int'(off);
    return 5'(s);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      SZ_BYTE: m = 32'h0000_00FF;
      SZ_HALF: m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_unit.sv
// Combinational lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_unit
  import lsu_mem_ctrl_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_shift;
  logic [31:0] w_mask;
  logic [31:0] w_lane;

  always_comb begin
    w_shift = lane_shift(i_off, i_size, BIG_ENDIAN);
    w_mask  = lane_mask(i_size);
    w_lane  = (i_word >> w_shift) & w_mask;
    o_load  = w_lane;
    if (!i_unsigned) begin
      if (i_size == SZ_BYTE)      o_load = {{24{w_lane[7]}}, w_lane[7:0]};
      else if (i_size == SZ_HALF) o_load = {{16{w_lane[15]}}, w_lane[15:0]};
    end
    o_merged = (i_word & ~(w_mask << w_shift)) | ((i_wdata & w_mask) << w_shift);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: byte-address decode, extended loads, read-modify-write
// sub-word stores, and fault capture (BadVAddr plus saturating counter).
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int WORD_ADDR_W = 8,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input  logic        clk,
  input  logic        SYS_reset,
  input  logic        LSU_req_load,
  input  logic        LSU_req_store,
  input  logic [1:0]  LSU_size,
  input  logic        LSU_unsigned,
  input  logic [31:0] LSU_addr,
  input  logic [31:0] LSU_wdata,
  output logic [31:0] LSU_rdata,
  output logic        LSU_stall,
  output logic        LSU_fault,
  output logic [31:0] LSU_fault_addr,
  output logic [7:0]  LSU_fault_cnt,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  lsu_state_t              r_state, w_state_next;
  logic [31:0]             r_merge;
  logic [WORD_ADDR_W-1:0]  r_word_idx;
  logic [31:0]             r_fault_addr;
  logic [7:0]              r_fault_cnt;

  logic [WORD_ADDR_W-1:0]  w_word_idx;
  logic [31:0]             w_load_data;
  logic [31:0]             w_merged;
  logic                    w_fault;
  logic                    w_load_ok;
  logic                    w_store_ok;
  logic                    w_sub_store;

  assign w_word_idx = LSU_addr[WORD_ADDR_W+1:2];

  lsu_lane_unit #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .i_word     (DMEM_data_out),
    .i_wdata    (LSU_wdata),
    .i_off      (LSU_addr[1:0]),
    .i_size     (LSU_size),
    .i_unsigned (LSU_unsigned),
    .o_load     (w_load_data),
    .o_merged   (w_merged)
  );

  // Requests are only decoded in IDLE; RMW_WR replays the held request.
  always_comb begin
    w_fault    = 1'b0;
    w_load_ok  = 1'b0;
    w_store_ok = 1'b0;
    if (!SYS_reset && r_state == ST_IDLE && (LSU_req_load || LSU_req_store)) begin
      w_fault = (LSU_req_load && LSU_req_store)
             || (LSU_size == SZ_ILL)
             || (LSU_size == SZ_HALF && LSU_addr[0])
             || (LSU_size == SZ_WORD && LSU_addr[1:0] != 2'b00)
             || (LSU_addr[31:WORD_ADDR_W+2] != '0);
      w_load_ok  = LSU_req_load  && !w_fault;
      w_store_ok = LSU_req_store && !w_fault;
    end
    w_sub_store = w_store_ok && (LSU_size != SZ_WORD);
  end

  always_comb begin
    w_state_next   = r_state;
    DMEM_mem_read  = 1'b0;
    DMEM_mem_write = 1'b0;
    LSU_stall      = 1'b0;
    LSU_rdata      = '0;
    DMEM_data_in   = LSU_wdata;
    DMEM_address   = {{(32-WORD_ADDR_W){1'b0}}, w_word_idx};
    case (r_state)
      ST_IDLE: begin
        DMEM_mem_read  = w_load_ok || w_sub_store;
        DMEM_mem_write = w_store_ok && !w_sub_store;
        LSU_stall      = w_sub_store;
        if (w_load_ok)   LSU_rdata    = w_load_data;
        if (w_sub_store) w_state_next = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        DMEM_mem_write = !SYS_reset;
        DMEM_data_in   = r_merge;
        DMEM_address   = {{(32-WORD_ADDR_W){1'b0}}, r_word_idx};
        w_state_next   = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (SYS_reset) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (SYS_reset) begin
      r_state      <= ST_IDLE;
      r_merge      <= '0;
      r_word_idx   <= '0;
      r_fault_addr <= '0;
      r_fault_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_sub_store) begin
        r_merge    <= w_merged;
        r_word_idx <= w_word_idx;
      end
      if (w_fault) begin
        r_fault_addr <= LSU_addr;
        if (r_fault_cnt != 8'hFF) r_fault_cnt <= r_fault_cnt + 8'd1;
      end
    end
  end

  assign LSU_fault      = w_fault;
  assign LSU_fault_addr = r_fault_addr;
  assign LSU_fault_cnt  = r_fault_cnt;

endmodule
